// File: rtl/shifter_pkg.sv
// Shared types for the sequential shift unit.
//   shift_mode_e  : operation selector (LSL, LSR, ASR, ROL)
//   shift_state_e : control FSM states (IDLE, SHIFT, DONE)
package shifter_pkg;

   typedef enum logic [1:0] {
      LSL = 2'd0,
      LSR = 2'd1,
      ASR = 2'd2,
      ROL = 2'd3
   } shift_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shift_state_e;

endpackage

// File: rtl/param_seq_shifter_shift_stage.sv
// shift_stage: combinational single step of the sequential shifter.
// Shifts value by s bits (0..WIDTH) according to mode.
// Ports:
//   value  in  WIDTH  operand for this step
//   s      in  CNT_W  distance for this step
//   mode   in  2      shift_mode_e
//   result out WIDTH  shifted value
//   carry  out 1      last bit moved out (ROL: last bit wrapped); 0 when s=0
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] value,
   input  logic [CNT_W-1:0] s,
   input  shift_mode_e      mode,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   // Left shifts run in a double-width window: the upper half collects the
   // bits pushed past the MSB, so bit WIDTH is always the last one out and
   // the upper half is exactly what a rotate wraps back to the LSB.
   logic [2*WIDTH-1:0] left_win;
   // Right shifts use fill bits above and one guard bit below the operand;
   // the guard bit ends up holding the last bit shifted out.
   logic [2*WIDTH:0]   right_win;
   logic [WIDTH-1:0]   fill;

   always_comb begin
      fill      = (mode == ASR) ? {WIDTH{value[WIDTH-1]}} : '0;
      left_win  = {{WIDTH{1'b0}}, value} << s;
      right_win = {fill, value, 1'b0} >> s;
      result    = '0;
      carry     = 1'b0;
      case (mode)
         LSL: begin
            result = left_win[WIDTH-1:0];
            carry  = left_win[WIDTH];
         end
         ROL: begin
            result = left_win[WIDTH-1:0] | left_win[2*WIDTH-1:WIDTH];
            carry  = left_win[WIDTH];
         end
         default: begin
            result = right_win[WIDTH:1];
            carry  = right_win[0];
         end
      endcase
   end

endmodule

// File: rtl/param_seq_shifter.sv
// param_seq_shifter: multi-cycle shift unit, STEP bits per clock.
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      asynchronous active-high reset
//   start     in  1      request, accepted in IDLE or DONE
//   mode      in  2      shift_mode_e
//   amount    in  CNT_W  total shift distance (clamped to WIDTH)
//   data_in   in  WIDTH  operand captured on accepted start
//   busy      out 1      high in SHIFT and DONE
//   done      out 1      result final during this cycle
//   data_out  out WIDTH  working register
//   carry_out out 1      last bit shifted out / wrapped
module param_seq_shifter
   import shifter_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int STEP  = 1,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  shift_mode_e      mode,
   input  logic [CNT_W-1:0] amount,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             carry_out
);

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);

   shift_state_e     state, state_next;
   shift_mode_e      mode_reg;
   logic [WIDTH-1:0] data_reg;
   logic             carry_reg;
   logic [CNT_W-1:0] rem;

   logic             accept;
   logic [CNT_W-1:0] amount_clamped;
   logic [CNT_W-1:0] step_s;
   logic [WIDTH-1:0] stage_result;
   logic             stage_carry;

   assign accept         = start && ((state == IDLE) || (state == DONE));
   // Clamping to WIDTH makes over-long rotates an identity and over-long
   // logical/arithmetic shifts saturate to zeros/sign bits.
   assign amount_clamped = (amount > WIDTH_C) ? WIDTH_C : amount;
   assign step_s         = (rem < STEP_C) ? rem : STEP_C;

   shift_stage #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_stage (
      .value  (data_reg),
      .s      (step_s),
      .mode   (mode_reg),
      .result (stage_result),
      .carry  (stage_carry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_next = (amount_clamped == '0) ? DONE : SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
            if (rem == step_s) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg  <= '0;
         carry_reg <= 1'b0;
         mode_reg  <= LSL;
         rem       <= '0;
      end else if (accept) begin
         data_reg  <= data_in;
         carry_reg <= 1'b0;
         mode_reg  <= mode;
         rem       <= amount_clamped;
      end else if (state == SHIFT) begin
         data_reg  <= stage_result;
         carry_reg <= stage_carry;
         rem       <= rem - step_s;
      end
   end

   assign busy      = (state == SHIFT) || (state == DONE);
   assign done      = (state == DONE);
   assign data_out  = data_reg;
   assign carry_out = carry_reg;

endmodule

// File: tb/tb_param_seq_shifter.sv
// Bench for param_seq_shifter: two instances (STEP=1 and STEP=4) driven by
// the same stimulus, each checked against an arithmetic reference model.
module tb_param_seq_shifter;
   import shifter_pkg::*;

   localparam int W = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   shift_mode_e mode;
   logic [5:0]  amount;
   logic [31:0] data_in;

   logic        busy_a, done_a, carry_a;
   logic [31:0] data_a;
   logic        busy_b, done_b, carry_b;
   logic [31:0] data_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   param_seq_shifter #(.WIDTH(W), .STEP(1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
      .data_in(data_in), .busy(busy_a), .done(done_a), .data_out(data_a),
      .carry_out(carry_a)
   );

   param_seq_shifter #(.WIDTH(W), .STEP(4)) dut_b (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
      .data_in(data_in), .busy(busy_b), .done(done_b), .data_out(data_b),
      .carry_out(carry_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Result of shifting d by amt in one go: {carry, value}.
   function automatic logic [32:0] model(input shift_mode_e m, input int amt, input logic [31:0] d);
      int          c;
      logic [63:0] w;
      logic [31:0] r;
      logic        cy;
      c  = (amt > W) ? W : amt;
      r  = d;
      cy = 1'b0;
      case (m)
         LSL: begin
            w = {32'b0, d} << c;
            r = w[31:0];
            if (c > 0) cy = d[W-c];
         end
         LSR: begin
            w = {32'b0, d} >> c;
            r = w[31:0];
            if (c > 0) cy = d[c-1];
         end
         ASR: begin
            w = {{32{d[31]}}, d} >> c;
            r = w[31:0];
            if (c > 0) cy = d[c-1];
         end
         default: begin
            if (c > 0 && c < W) r = (d << c) | (d >> (W - c));
            if (c > 0) cy = d[W-c];
         end
      endcase
      return {cy, r};
   endfunction

   function automatic int cycles_for(input int amt, input int step);
      int c;
      c = (amt > W) ? W : amt;
      return (c + step - 1) / step;
   endfunction

   // Issue one operation (task entered just after a negedge) and wait for
   // both instances to signal done. poke pulses start once during SHIFT.
   task automatic run_op(input shift_mode_e m, input int amt, input logic [31:0] d, input bit poke);
      logic [32:0] exp_r;
      int          lat_a, lat_b;
      logic [31:0] res_a, res_b;
      logic        cy_a, cy_b, bz_a, bz_b;
      mode    = m;
      amount  = 6'(amt);
      data_in = d;
      start   = 1'b1;
      lat_a = 0; lat_b = 0;
      res_a = '0; res_b = '0; cy_a = 1'b0; cy_b = 1'b0; bz_a = 1'b0; bz_b = 1'b0;
      for (int n = 1; n <= 45 && (lat_a == 0 || lat_b == 0); n++) begin
         @(negedge clk);
         if (done_a && lat_a == 0) begin
            lat_a = n; res_a = data_a; cy_a = carry_a; bz_a = busy_a;
         end
         if (done_b && lat_b == 0) begin
            lat_b = n; res_b = data_b; cy_b = carry_b; bz_b = busy_b;
         end
         if (poke && n == 2) begin
            start   = 1'b1;
            data_in = $urandom;
            mode    = shift_mode_e'(2'($urandom_range(0, 3)));
         end else begin
            start = 1'b0;
         end
      end
      exp_r = model(m, amt, d);
      check("lat_a",   64'(lat_a), 64'(cycles_for(amt, 1) + 1));
      check("data_a",  64'(res_a), 64'(exp_r[31:0]));
      check("carry_a", 64'(cy_a),  64'(exp_r[32]));
      check("busy_a",  64'(bz_a),  64'd1);
      check("lat_b",   64'(lat_b), 64'(cycles_for(amt, 4) + 1));
      check("data_b",  64'(res_b), 64'(exp_r[31:0]));
      check("carry_b", 64'(cy_b),  64'(exp_r[32]));
      @(negedge clk);
      check("idle_busy_a", 64'(busy_a), 64'd0);
      check("idle_done_b", 64'(done_b), 64'd0);
      check("hold_data_a", 64'(data_a), 64'(exp_r[31:0]));
      $display("op mode=%0d amount=%0d data=0x%08h -> a=0x%08h/%0b lat %0d, b=0x%08h/%0b lat %0d%s",
               m, amt, d, res_a, cy_a, lat_a, res_b, cy_b, lat_b, poke ? " (poked)" : "");
   endtask

   initial begin
      int          cnt_a, cnt_b;
      logic [31:0] d;
      logic [32:0] exp_r;
      reset = 1'b1; start = 1'b0; mode = LSL; amount = '0; data_in = '0;
      #1;
      check("rst_data_a", 64'(data_a), 64'd0);
      check("rst_busy_a", 64'(busy_a), 64'd0);
      check("rst_done_b", 64'(done_b), 64'd0);
      check("rst_carry_b", 64'(carry_b), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of an LSL operation.
      mode = LSL; amount = 6'd10; data_in = 32'hDEAD_BEEF; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_data_a", 64'(data_a), 64'd0);
      check("midrst_busy_a", 64'(busy_a), 64'd0);
      check("midrst_done_a", 64'(done_a), 64'd0);
      check("midrst_carry_a", 64'(carry_a), 64'd0);
      check("midrst_busy_b", 64'(busy_b), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("postrst_busy_a", 64'(busy_a), 64'd0);
      $display("reset mid-operation applied");

      // Directed cases.
      run_op(LSL, 4,  32'h0000_0001, 1'b0);
      run_op(ASR, 31, 32'h8000_0000, 1'b0);
      run_op(ASR, 40, 32'h8000_0000, 1'b0);
      run_op(ROL, 1,  32'h8000_0001, 1'b0);
      run_op(ROL, 0,  32'h8000_0001, 1'b0);
      run_op(LSR, 6,  32'hF000_0000, 1'b0);
      run_op(LSL, 32, 32'hFFFF_FFFF, 1'b0);
      run_op(LSR, 33, 32'h1234_5678, 1'b0);
      run_op(ROL, 45, 32'hA5A5_0F0F, 1'b0);
      run_op(ASR, 7,  32'h7000_0080, 1'b0);
      run_op(LSL, 20, 32'h0001_2345, 1'b1);
      run_op(ROL, 13, 32'hC001_D00D, 1'b1);

      // Start held high: back-to-back ops, one done pulse per k+1 cycles.
      d = $urandom;
      mode = LSL; amount = 6'd3; data_in = d; start = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         if (done_a) cnt_a++;
         if (done_b) cnt_b++;
         if (n == 16) begin
            exp_r = model(LSL, 3, d);
            check("b2b_last_done_a", 64'(done_a), 64'd1);
            check("b2b_data_a", 64'(data_a), 64'(exp_r[31:0]));
            check("b2b_data_b", 64'(data_b), 64'(exp_r[31:0]));
            start = 1'b0;
         end
      end
      check("b2b_pulses_a", 64'(cnt_a), 64'd4);
      check("b2b_pulses_b", 64'(cnt_b), 64'd8);
      $display("back-to-back LSL by 3: %0d pulses (STEP=1), %0d pulses (STEP=4)", cnt_a, cnt_b);
      @(negedge clk);
      check("b2b_idle_a", 64'(busy_a), 64'd0);

      // Randomised operations.
      for (int i = 0; i < 40; i++) begin
         run_op(shift_mode_e'(2'($urandom_range(0, 3))), int'($urandom_range(0, 40)),
                $urandom, ($urandom_range(0, 3) == 0) && 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         run_op(shift_mode_e'(2'($urandom_range(0, 3))), int'($urandom_range(12, 40)),
                $urandom, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
